// File: rtl/sequence_counter.sv
// Control-unit step counter: produces the 4-bit step index feeding the T0..T15 decoder.
// HALTED/RUN control, memory-wait stall, sticky runaway-step flag, retired-instruction count.
module sequence_counter #(
   parameter int unsigned MAX_STEP = 15
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        halt_i,
   input  logic        clear_i,
   input  logic        stall_i,
   output logic [3:0]  step_counter_o,
   output logic        running_o,
   output logic        new_instr_o,
   output logic        step_overflow_o,
   output logic [15:0] instr_count_o
);

   localparam logic [3:0] MaxStepW = 4'(MAX_STEP);

   typedef enum logic [0:0] {StHalted, StRun} state_e;

   state_e      state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic        ovf_q, ovf_d;
   logic [15:0] count_q, count_d;

   // Next-state logic: Halt beats Clear beats Stall beats normal advance.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      unique case (state_q)
         StHalted: begin
            step_d = 4'd0;
            if (start_i && !halt_i) begin
               state_d = StRun;
            end
         end
         StRun: begin
            // The instruction ending on this edge retires even if it is HLT.
            if (clear_i) begin
               count_d = count_q + 16'd1;
            end
            if (halt_i) begin
               state_d = StHalted;
               step_d  = 4'd0;
            end else if (clear_i) begin
               step_d = 4'd0;
            end else if (stall_i) begin
               step_d = step_q;
            end else if (step_q == MaxStepW) begin
               // Runaway instruction: wrap and flag, but keep running.
               step_d = 4'd0;
               ovf_d  = 1'b1;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         default: begin
            state_d = StHalted;
            step_d  = 4'd0;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StHalted;
         step_q  <= 4'd0;
         ovf_q   <= 1'b0;
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
      end
   end

   // Outputs decoded from registers only.
   always_comb begin
      running_o       = (state_q == StRun);
      step_counter_o  = step_q;
      new_instr_o     = running_o && (step_q == 4'd0);
      step_overflow_o = ovf_q;
      instr_count_o   = count_q;
   end

endmodule

// File: tb/tb_sequence_counter.sv
// Self-checking bench: two DUTs (MAX_STEP 15 and 7) share stimulus; a rule-level model is
// compared every cycle, plus directed literal expectations.
module tb_sequence_counter;

   logic clk;
   logic reset, start, halt, clear, stall;

   logic [3:0]  step_a, step_b;
   logic        run_a, run_b, ni_a, ni_b, ovf_a, ovf_b;
   logic [15:0] cnt_a, cnt_b;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   // Model state, index 0 -> MAX_STEP 15, index 1 -> MAX_STEP 7.
   int m_max  [2] = '{15, 7};
   int m_run  [2];
   int m_step [2];
   int m_ovf  [2];
   int m_cnt  [2];

   sequence_counter #(.MAX_STEP(15)) u_dut_a (
      .clk_i(clk), .reset_i(reset), .start_i(start), .halt_i(halt), .clear_i(clear),
      .stall_i(stall), .step_counter_o(step_a), .running_o(run_a), .new_instr_o(ni_a),
      .step_overflow_o(ovf_a), .instr_count_o(cnt_a)
   );

   sequence_counter #(.MAX_STEP(7)) u_dut_b (
      .clk_i(clk), .reset_i(reset), .start_i(start), .halt_i(halt), .clear_i(clear),
      .stall_i(stall), .step_counter_o(step_b), .running_o(run_b), .new_instr_o(ni_b),
      .step_overflow_o(ovf_b), .instr_count_o(cnt_b)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Model: apply the operating rules to the inputs sampled on each rising edge.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_run[d] = 0; m_step[d] = 0; m_ovf[d] = 0; m_cnt[d] = 0;
         end else if (m_run[d] == 0) begin
            m_step[d] = 0;
            if (start && !halt) m_run[d] = 1;
         end else begin
            if (clear) m_cnt[d] = (m_cnt[d] + 1) % 65536;
            if (halt) begin
               m_run[d] = 0; m_step[d] = 0;
            end else if (clear) begin
               m_step[d] = 0;
            end else if (stall) begin
               m_step[d] = m_step[d];
            end else if (m_step[d] == m_max[d]) begin
               m_step[d] = 0; m_ovf[d] = 1;
            end else begin
               m_step[d] = m_step[d] + 1;
            end
         end
      end
   end

   task automatic cmp_dut(input string name, input int d, input int st, input int rn,
                          input int ni, input int ov, input int cn);
      int e_ni;
      e_ni = (m_run[d] != 0 && m_step[d] == 0) ? 1 : 0;
      n_checks++;
      if (st == m_step[d] && rn == m_run[d] && ni == e_ni && ov == m_ovf[d] && cn == m_cnt[d])
         n_pass++;
      else
         $display("FAIL %s t=%0t got step=%0d run=%0d ni=%0d ovf=%0d cnt=%0d exp step=%0d run=%0d ni=%0d ovf=%0d cnt=%0d",
                  name, $time, st, rn, ni, ov, cn, m_step[d], m_run[d], e_ni, m_ovf[d], m_cnt[d]);
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp_dut("model_a", 0, int'(step_a), int'(run_a), int'(ni_a), int'(ovf_a), int'(cnt_a));
         cmp_dut("model_b", 1, int'(step_b), int'(run_b), int'(ni_b), int'(ovf_b), int'(cnt_b));
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", name, act, exp);
   endtask

   // One clock: drive inputs, take the edge, settle 2 time units after it.
   task automatic cyc(input bit r, input bit s, input bit h, input bit c, input bit st);
      reset = r; start = s; halt = h; clear = c; stall = st;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic all_zero(input string name);
      lit({name, "_step"}, int'(step_a), 0);
      lit({name, "_run"},  int'(run_a), 0);
      lit({name, "_ni"},   int'(ni_a), 0);
      lit({name, "_ovf"},  int'(ovf_a), 0);
      lit({name, "_cnt"},  int'(cnt_a), 0);
      lit({name, "_b"},    int'({step_b, run_b, ni_b, ovf_b, cnt_b}), 0);
   endtask

   initial begin
      reset = 1; start = 0; halt = 0; clear = 0; stall = 0;

      // Reset then start.
      cyc(1, 0, 0, 0, 0);
      chk_en = 1;
      all_zero("rst1");
      cyc(1, 0, 0, 0, 0);
      all_zero("rst2");
      cyc(0, 1, 0, 0, 0);
      lit("start_run", int'(run_a), 1);
      lit("start_step", int'(step_a), 0);
      lit("start_ni", int'(ni_a), 1);
      for (int i = 1; i <= 4; i++) begin
         idle(1);
         lit("run_step", int'(step_a), i);
         lit("run_ni", int'(ni_a), 0);
      end

      // Clear at step 3, three times.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         idle(3);
         lit("clr_step3", int'(step_a), 3);
         cyc(0, 0, 0, 1, 0);
         lit("clr_step0", int'(step_a), 0);
         lit("clr_ni", int'(ni_a), 1);
      end
      lit("clr_cnt", int'(cnt_a), 3);

      // Stall at step 2 for three cycles, Clear on the last.
      idle(2);
      lit("stall_s0", int'(step_a), 2);
      cyc(0, 0, 0, 0, 1);
      lit("stall_s1", int'(step_a), 2);
      cyc(0, 0, 0, 0, 1);
      lit("stall_s2", int'(step_a), 2);
      cyc(0, 0, 0, 1, 1);
      lit("stall_clr", int'(step_a), 0);
      lit("stall_cnt", int'(cnt_a), 4);

      // Overflow with MAX_STEP 7 (DUT b).
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      idle(7);
      lit("ovf_b_s7", int'(step_b), 7);
      lit("ovf_b_pre", int'(ovf_b), 0);
      idle(1);
      lit("ovf_b_wrap", int'(step_b), 0);
      lit("ovf_b_set", int'(ovf_b), 1);
      lit("ovf_a_clear", int'(ovf_a), 0);
      idle(1);
      lit("ovf_b_s1", int'(step_b), 1);
      cyc(0, 0, 1, 0, 0);
      lit("ovf_b_halt", int'(ovf_b), 1);
      lit("ovf_b_halted", int'(run_b), 0);
      cyc(0, 1, 0, 0, 0);
      lit("ovf_b_restart", int'(ovf_b), 1);
      lit("ovf_b_running", int'(run_b), 1);

      // Overflow with MAX_STEP 15 (DUT a).
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      idle(15);
      lit("ovf_a_s15", int'(step_a), 15);
      lit("ovf_a_pre", int'(ovf_a), 0);
      idle(1);
      lit("ovf_a_wrap", int'(step_a), 0);
      lit("ovf_a_set", int'(ovf_a), 1);

      // Halt together with Clear, then Start&Halt, then Start alone.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      idle(5);
      lit("halt_s5", int'(step_a), 5);
      cyc(0, 0, 1, 1, 0);
      lit("halt_run", int'(run_a), 0);
      lit("halt_step", int'(step_a), 0);
      lit("halt_cnt", int'(cnt_a), 1);
      cyc(0, 0, 0, 1, 1);
      lit("halted_ign_cnt", int'(cnt_a), 1);
      lit("halted_ign_run", int'(run_a), 0);
      cyc(0, 1, 1, 0, 0);
      lit("sh_run", int'(run_a), 0);
      cyc(0, 1, 0, 0, 0);
      lit("restart_run", int'(run_a), 1);
      lit("restart_step", int'(step_a), 0);
      lit("restart_ni", int'(ni_a), 1);

      // InstrCount wrap, then reset with Clear mid-instruction.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 65535; i++) cyc(0, 0, 0, 1, 0);
      lit("wrap_ffff", int'(cnt_a), 65535);
      cyc(0, 0, 0, 1, 0);
      lit("wrap_zero", int'(cnt_a), 0);
      cyc(0, 0, 0, 1, 0);
      idle(4);
      lit("mid_s4", int'(step_a), 4);
      lit("mid_cnt", int'(cnt_a), 1);
      cyc(1, 0, 0, 1, 0);
      all_zero("mid_rst");

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
